// File: rtl/flit_gen_pkg.sv
// Shared types and counter widths for the flit pattern generator.
package flit_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_e;
  typedef enum logic [1:0] {MODE_THERM, MODE_CNT, MODE_LFSR, MODE_CONST} mode_e;
  localparam int LEN_W = 8;
  localparam int GAP_W = 8;
  localparam int PKT_W = 16;
  localparam int TGL_W = 32;
endpackage

// File: rtl/flit_pattern_next.sv
// Combinational pattern successor; on head the walk restarts from the mode's reset value.
module flit_pattern_next
  import flit_gen_pkg::*;
#(
  parameter int            W         = 36,
  parameter int            STEP_BITS = 2,
  parameter logic [W-1:0]  LFSR_TAPS = 36'h800000803,
  parameter logic [W-1:0]  LFSR_SEED = 36'h000000001
)(
  input  mode_e          mode,
  input  logic [W-1:0]   cur,
  input  logic           head,
  output logic [W-1:0]   next
);
  logic [W-1:0] base;
  logic         fill;

  always_comb begin
    base = cur;
    if (head) begin
      case (mode)
        MODE_LFSR:  base = LFSR_SEED;
        MODE_CONST: base = '1;
        default:    base = '0;
      endcase
    end
    // Filling words have ones on the MSB side; draining words keep ones on the LSB side.
    fill = (base == '0) || (base[W-1] && (base != '1));
    case (mode)
      MODE_THERM: next = fill ? {{STEP_BITS{1'b1}}, base[W-1:STEP_BITS]}
                              : {{STEP_BITS{1'b0}}, base[W-1:STEP_BITS]};
      MODE_CNT:   next = base + W'(1);
      MODE_LFSR:  next = {base[W-2:0], ^(base & LFSR_TAPS)};
      default:    next = '1;
    endcase
  end
endmodule

// File: rtl/flit_pattern_gen.sv
// Packetised test-pattern source with gap control, valid/ready handshake and toggle accounting.
module flit_pattern_gen
  import flit_gen_pkg::*;
#(
  parameter int            W         = 36,
  parameter int            STEP_BITS = 2,
  parameter logic [W-1:0]  LFSR_TAPS = 36'h800000803,
  parameter logic [W-1:0]  LFSR_SEED = 36'h000000001
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [PKT_W-1:0]  cfg_pkts,
  output logic [W-1:0]      flit_data,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic              flit_head,
  output logic              flit_tail,
  output logic              busy,
  output logic              done,
  output logic [TGL_W-1:0]  toggle_cnt
);
  state_e            state, state_nxt;
  mode_e             mode_q, mode_sel;
  logic [LEN_W-1:0]  len_q, len_in, len_sel, flit_idx;
  logic [GAP_W-1:0]  gap_q, gap_cnt;
  logic [PKT_W-1:0]  pkts_q, pkt_idx;
  logic [W-1:0]      succ, last_acc, diff;
  logic [TGL_W-1:0]  flips;
  logic [TGL_W:0]    tgl_sum;
  logic              xfer, tail_xfer, last_pkt, gap_end, load_head, advance;

  assign xfer      = flit_valid & flit_ready;
  assign tail_xfer = xfer & flit_tail;
  assign last_pkt  = (pkt_idx == pkts_q - PKT_W'(1));
  assign gap_end   = (gap_cnt == gap_q - GAP_W'(1));
  assign len_in    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  // Config is only live while idle; afterwards the sampled copies rule.
  assign mode_sel  = (state == IDLE) ? mode_e'(cfg_mode) : mode_q;
  assign len_sel   = (state == IDLE) ? len_in : len_q;

  flit_pattern_next #(
    .W(W), .STEP_BITS(STEP_BITS), .LFSR_TAPS(LFSR_TAPS), .LFSR_SEED(LFSR_SEED)
  ) u_next (
    .mode(mode_sel), .cur(flit_data), .head(load_head), .next(succ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: if (tail_xfer) begin
        if (gap_q != '0)   state_nxt = GAP;
        else if (last_pkt) state_nxt = FIN;
      end
      GAP:  if (gap_end) state_nxt = last_pkt ? FIN : SEND;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    load_head = ((state == IDLE) && start)
             || ((state == SEND) && tail_xfer && (gap_q == '0) && !last_pkt)
             || ((state == GAP) && gap_end && !last_pkt);
    advance   = (state == SEND) && xfer && !flit_tail;
  end

  always_comb begin
    diff  = flit_data ^ last_acc;
    flips = '0;
    for (int i = 0; i < W; i++) flips = flips + TGL_W'(diff[i]);
    tgl_sum = {1'b0, toggle_cnt} + {1'b0, flips};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_THERM;
      len_q      <= '0;
      gap_q      <= '0;
      pkts_q     <= '0;
      flit_idx   <= '0;
      pkt_idx    <= '0;
      gap_cnt    <= '0;
      flit_data  <= '0;
      flit_valid <= 1'b0;
      flit_head  <= 1'b0;
      flit_tail  <= 1'b0;
      last_acc   <= '0;
      toggle_cnt <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        mode_q <= mode_e'(cfg_mode);
        len_q  <= len_in;
        gap_q  <= cfg_gap;
        pkts_q <= (cfg_pkts == '0) ? PKT_W'(1) : cfg_pkts;
      end
      if (load_head) begin
        flit_data  <= succ;
        flit_valid <= 1'b1;
        flit_head  <= 1'b1;
        flit_tail  <= (len_sel == LEN_W'(1));
        flit_idx   <= '0;
        pkt_idx    <= (state == IDLE) ? '0 : pkt_idx + PKT_W'(1);
      end else if (advance) begin
        flit_data  <= succ;
        flit_head  <= 1'b0;
        flit_tail  <= (flit_idx + LEN_W'(2) == len_q);
        flit_idx   <= flit_idx + LEN_W'(1);
      end else if (tail_xfer) begin
        flit_valid <= 1'b0;
        flit_head  <= 1'b0;
        flit_tail  <= 1'b0;
      end
      if (tail_xfer)           gap_cnt <= '0;
      else if (state == GAP)   gap_cnt <= gap_cnt + GAP_W'(1);
      if (xfer) begin
        last_acc   <= flit_data;
        toggle_cnt <= tgl_sum[TGL_W] ? '1 : tgl_sum[TGL_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_flit_pattern_gen.sv
// Directed bench: expected flits are queued at start and matched against every accepted transfer.
module tb_flit_pattern_gen;
  localparam int W = 36;
  localparam int S = 2;
  localparam logic [W-1:0] TAPS = 36'h800000803;
  localparam logic [W-1:0] SEED = 36'h000000001;
  typedef logic [W-1:0] flit_t;
  typedef struct { flit_t data; logic head; logic tail; } exp_t;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flit_ready = 1'b1;
  logic [1:0]  cfg_mode = 2'd0;
  logic [7:0]  cfg_len = 8'd0, cfg_gap = 8'd0;
  logic [15:0] cfg_pkts = 16'd0;
  flit_t       flit_data;
  logic        flit_valid, flit_head, flit_tail, busy, done;
  logic [31:0] toggle_cnt;

  always #5 clk = ~clk;

  flit_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .cfg_gap(cfg_gap), .cfg_pkts(cfg_pkts), .flit_data(flit_data), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .flit_head(flit_head), .flit_tail(flit_tail), .busy(busy),
    .done(done), .toggle_cnt(toggle_cnt)
  );

  int    checks = 0, errors = 0;
  exp_t  sb[$];
  flit_t acc[$];
  int    cyc = 0, xfers = 0, done_cnt = 0, last_tail_cyc = 0, inval = 0, exp_gap = 0;
  bit    after_tail = 0, stall_prev = 0;
  flit_t held_d, exp_last = '0;
  logic  held_h, held_t;
  logic [31:0] exp_tgl = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference pattern: value of the k-th flit (1-based) of a packet.
  function automatic flit_t exp_flit(input logic [1:0] mode, input int k);
    flit_t v;
    int kk;
    v = '1;
    case (mode)
      2'd0: begin
        kk = (k - 1) % (2 * W / S) + 1;
        if (kk <= W / S) v = ~(v >> (kk * S));
        else             v = v >> ((kk - W / S) * S);
      end
      2'd1: v = flit_t'(k);
      2'd2: begin
        v = SEED;
        for (int i = 0; i < k; i++) v = {v[W-2:0], ^(v & TAPS)};
      end
      default: v = '1;
    endcase
    return v;
  endfunction

  task automatic push_run(input logic [1:0] m, input int len, input int gap, input int pkts);
    int l, p;
    exp_t e;
    l = (len == 0) ? 1 : len;
    p = (pkts == 0) ? 1 : pkts;
    for (int j = 0; j < p; j++)
      for (int k = 1; k <= l; k++) begin
        e.data = exp_flit(m, k);
        e.head = (k == 1);
        e.tail = (k == l);
        sb.push_back(e);
      end
    exp_gap = gap;
  endtask

  task automatic go(input logic [1:0] m, input int len, input int gap, input int pkts);
    push_run(m, len, gap, pkts);
    cfg_mode = m; cfg_len = 8'(len); cfg_gap = 8'(gap); cfg_pkts = 16'(pkts);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin tick(); n++; end
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed done=%b expected 1 within %0d cycles", tag, done, max);
    end
    tick();
  endtask

  // Transfer monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_prev = 0; after_tail = 0; inval = 0;
    end else begin
      exp_t e;
      cyc++;
      if (stall_prev) begin
        chk("stall_valid", flit_valid, 1'b1);
        chk("stall_data", flit_data, held_d);
        chk("stall_head", flit_head, held_h);
        chk("stall_tail", flit_tail, held_t);
      end
      stall_prev = flit_valid && !flit_ready;
      held_d = flit_data; held_h = flit_head; held_t = flit_tail;
      if (!flit_valid && after_tail) inval++;
      if (flit_valid && flit_head && after_tail) begin
        chk("gap_len", inval, exp_gap);
        after_tail = 0;
      end
      if (flit_valid && flit_ready) begin
        if (sb.size() == 0) chk("unexpected_flit", flit_data, 0);
        else begin
          logic [32:0] s;
          e = sb.pop_front();
          chk("flit_data", flit_data, e.data);
          chk("flit_head", flit_head, e.head);
          chk("flit_tail", flit_tail, e.tail);
          s = {1'b0, exp_tgl} + 33'($countones(e.data ^ exp_last));
          exp_tgl = s[32] ? 32'hFFFFFFFF : s[31:0];
          exp_last = e.data;
        end
        acc.push_back(flit_data);
        xfers++;
        if (flit_tail) begin last_tail_cyc = cyc; after_tail = 1; inval = 0; end
      end
      if (done) begin
        done_cnt++;
        if (after_tail) chk("done_latency", cyc - last_tail_cyc, exp_gap + 1);
        after_tail = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, x0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", flit_data, 0);
    chk("rst_valid", flit_valid, 0);
    chk("rst_head", flit_head, 0);
    chk("rst_tail", flit_tail, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_toggle", toggle_cnt, 0);
    rst = 1'b0;
    tick();

    // Thermometer walk, single packet.
    acc.delete();
    go(2'd0, 20, 7, 1);
    wait_done("therm_done", 100);
    chk("therm_count", acc.size(), 20);
    chk("therm_f1", acc[0], 36'hC00000000);
    chk("therm_f18", acc[17], 36'hFFFFFFFFF);
    chk("therm_f19", acc[18], 36'h3FFFFFFFF);
    chk("therm_f20", acc[19], 36'h0FFFFFFFF);
    chk("therm_toggle", toggle_cnt, 40);
    chk("therm_sb_empty", sb.size(), 0);

    // Ten packets with a 7-cycle gap.
    d0 = done_cnt; x0 = xfers;
    go(2'd0, 20, 7, 10);
    wait_done("gap_done", 400);
    tick(3);
    chk("gap_xfers", xfers - x0, 200);
    chk("gap_done_once", done_cnt - d0, 1);
    chk("gap_toggle", toggle_cnt, exp_tgl);
    chk("gap_sb_empty", sb.size(), 0);

    // Count mode under alternating backpressure.
    acc.delete();
    go(2'd1, 6, 0, 2);
    n = 0;
    while (done !== 1'b1 && n < 200) begin flit_ready = ~flit_ready; tick(); n++; end
    flit_ready = 1'b1;
    chk("bp_done_seen", done, 1);
    tick();
    chk("bp_count", acc.size(), 12);
    for (int i = 0; i < 12 && i < acc.size(); i++) chk("bp_seq", acc[i], (i % 6) + 1);
    chk("bp_toggle", toggle_cnt, exp_tgl);

    // Zero length/gap/packets degenerate to a single flit.
    acc.delete();
    go(2'd0, 0, 0, 0);
    wait_done("edge_done", 20);
    chk("edge_count", acc.size(), 1);
    chk("edge_data", acc[0], 36'hC00000000);

    // Reset while flit 5 is on the bus.
    d0 = done_cnt;
    go(2'd0, 20, 0, 1);
    tick(4);
    chk("mid_f5", flit_data, 36'hFFC000000);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", flit_valid, 0);
    chk("mid_rst_data", flit_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_toggle", toggle_cnt, 0);
    sb.delete(); exp_tgl = '0; exp_last = '0;
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("mid_no_done", done_cnt - d0, 0);
    acc.delete();
    go(2'd0, 3, 0, 1);
    wait_done("restart_done", 20);
    chk("restart_f1", acc[0], 36'hC00000000);
    chk("restart_toggle", toggle_cnt, exp_tgl);

    // LFSR run with a stray start mid-packet.
    acc.delete();
    d0 = done_cnt;
    go(2'd2, 3, 0, 2);
    tick(2);
    cfg_mode = 2'd3; cfg_len = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    wait_done("lfsr_done", 40);
    chk("lfsr_count", acc.size(), 6);
    for (int i = 0; i < 6 && i < acc.size(); i++) chk("lfsr_seq", acc[i], exp_flit(2'd2, (i % 3) + 1));
    chk("lfsr_done_once", done_cnt - d0, 1);

    // Start raised on the done cycle must not launch a run.
    go(2'd3, 1, 0, 1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    chk("coinc_done_seen", done, 1);
    start = 1'b1; tick(); start = 1'b0;
    tick(4);
    chk("coinc_busy", busy, 0);
    chk("coinc_valid", flit_valid, 0);
    chk("coinc_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
